// File: rtl/if_fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-memory req/gnt/rvalid port plus the decode valid/ready port.
// The master modport is the fetch controller; the slave modport is memory plus decode.
interface if_fetch_ctrl_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc_plus4_o;

  modport master (
    output imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o, id_pc_plus4_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o, id_pc_plus4_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch sequencer: credit-limited memory requests, in-order instruction FIFO, redirect/drain.
// Optional feature macro MISALIGN_TRAP_EN: misaligned redirect targets raise a held trap instead of being aligned.
module if_fetch_ctrl #(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_i,
  input  logic [31:0]           redirect_pc_i,
  if_fetch_ctrl_if.master       bus,
  output logic                  misalign_o,
  output logic [31:0]           misalign_addr_o
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, TRAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1} state_t;
`endif

  state_t         state_reg, state_next;
  logic [31:0]    fetch_pc_reg, fetch_pc_next;
  logic [31:0]    resp_pc_reg, resp_pc_next;
  logic [CW-1:0]  outstanding_reg, outstanding_next;
  logic [CW-1:0]  drop_cnt_reg, drop_cnt_next;
  logic [CW-1:0]  count_reg, count_next;
  logic [PW-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [31:0]    pc_mem [FIFO_DEPTH];
  logic [31:0]    instr_mem [FIFO_DEPTH];

  logic        credit_ok, req, fire, fifo_empty, id_valid, push, pop;
  logic [31:0] redirect_tgt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

`ifdef MISALIGN_TRAP_EN
  logic [31:0] misalign_addr_reg, misalign_addr_next;
  assign redirect_tgt    = redirect_pc_i;
  assign misalign_o      = (state_reg == TRAP);
  assign misalign_addr_o = (state_reg == TRAP) ? misalign_addr_reg : 32'h0;
`else
  assign redirect_tgt    = redirect_pc_i & ~32'h3;
  assign misalign_o      = 1'b0;
  assign misalign_addr_o = 32'h0;
`endif

  // Requests are limited so every granted response is guaranteed a FIFO slot.
  assign credit_ok  = ({1'b0, outstanding_reg} + {1'b0, count_reg}) < {1'b0, DEPTH_C};
  assign req        = !rst && (state_reg == RUN) && credit_ok;
  assign fire       = req && bus.imem_gnt_i;
  assign fifo_empty = (count_reg == '0);
  assign id_valid   = !fifo_empty && !redirect_i;
  assign pop        = id_valid && bus.id_ready_i;
  assign push       = (state_reg == RUN) && bus.imem_rvalid_i && !redirect_i;

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = fetch_pc_reg;
  assign bus.id_valid_o    = id_valid;
  assign bus.id_instr_o    = fifo_empty ? 32'h0 : instr_mem[rd_ptr_reg];
  assign bus.id_pc_o       = fifo_empty ? 32'h0 : pc_mem[rd_ptr_reg];
  assign bus.id_pc_plus4_o = fifo_empty ? 32'h0 : pc_mem[rd_ptr_reg] + 32'd4;

  always_comb begin
    state_next       = state_reg;
    fetch_pc_next    = fetch_pc_reg;
    resp_pc_next     = resp_pc_reg;
    outstanding_next = outstanding_reg + CW'(fire) - CW'(bus.imem_rvalid_i);
    drop_cnt_next    = drop_cnt_reg;
    count_next       = count_reg;
    rd_ptr_next      = rd_ptr_reg;
    wr_ptr_next      = wr_ptr_reg;
`ifdef MISALIGN_TRAP_EN
    misalign_addr_next = misalign_addr_reg;
`endif
    if (redirect_i) begin
      // Everything still in flight after this edge belongs to the old path.
      fetch_pc_next = redirect_tgt;
      resp_pc_next  = redirect_tgt;
      drop_cnt_next = outstanding_next;
      count_next    = '0;
      rd_ptr_next   = '0;
      wr_ptr_next   = '0;
      state_next    = (outstanding_next != '0) ? DRAIN : RUN;
`ifdef MISALIGN_TRAP_EN
      if (redirect_tgt[1:0] != 2'b00) begin
        state_next         = TRAP;
        misalign_addr_next = redirect_tgt;
      end
`endif
    end else begin
      if (fire) fetch_pc_next = fetch_pc_reg + 32'd4;
      if (push) begin
        resp_pc_next = resp_pc_reg + 32'd4;
        wr_ptr_next  = ptr_inc(wr_ptr_reg);
      end
      if (pop) rd_ptr_next = ptr_inc(rd_ptr_reg);
      count_next = count_reg + CW'(push) - CW'(pop);
      if (bus.imem_rvalid_i && (state_reg != RUN) && (drop_cnt_reg != '0)) begin
        drop_cnt_next = drop_cnt_reg - CW'(1);
        if ((state_reg == DRAIN) && (drop_cnt_reg == CW'(1))) state_next = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= RUN;
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
      count_reg       <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
`ifdef MISALIGN_TRAP_EN
      misalign_addr_reg <= 32'h0;
`endif
    end else begin
      state_reg       <= state_next;
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
      count_reg       <= count_next;
      rd_ptr_reg      <= rd_ptr_next;
      wr_ptr_reg      <= wr_ptr_next;
`ifdef MISALIGN_TRAP_EN
      misalign_addr_reg <= misalign_addr_next;
`endif
    end
  end

  // Storage needs no reset: the count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]    <= resp_pc_reg;
      instr_mem[wr_ptr_reg] <= bus.imem_rdata_i;
    end
  end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_if_fetch_ctrl;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        misalign_o;
  logic [31:0] misalign_addr_o;

  if_fetch_ctrl_if bus ();

  if_fetch_ctrl #(.FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .bus(bus), .misalign_o(misalign_o), .misalign_addr_o(misalign_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; int cyc; bit wrong;} req_t;
  typedef struct {logic [31:0] addr; int cyc;} gnt_t;
  typedef struct {logic [31:0] pc; logic [31:0] plus4; logic [31:0] instr; int cyc;} del_t;

  req_t        mem_q[$];
  logic [31:0] fifo_q[$];
  gnt_t        gnt_q[$];
  del_t        del_q[$];

  int n_vec = 0, n_err = 0, cyc = 0;
  int gnt_pct, rv_pct, rdy_pct;
  bit redir;
  logic [31:0] redir_pc;
  logic [31:0] exp_fetch, trap_addr;
  bit trap_m;

  bit obs_req, obs_valid, obs_mis, obs_rv, obs_gnt, obs_rdy;
  logic [31:0] obs_addr, obs_pc, obs_plus4, obs_instr, obs_mis_addr;
  bit exp_req, exp_valid, exp_mis;
  logic [31:0] exp_addr, exp_pc, exp_mis_addr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
  endfunction

  function automatic logic [31:0] align_tgt(input logic [31:0] t);
`ifdef MISALIGN_TRAP_EN
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  function automatic int first_gnt(input int rc);
    foreach (gnt_q[i]) if (gnt_q[i].cyc > rc) return i;
    return -1;
  endfunction

  function automatic int first_del(input int rc);
    foreach (del_q[i]) if (del_q[i].cyc > rc) return i;
    return -1;
  endfunction

  task automatic set_knobs(input int g, input int v, input int r);
    gnt_pct = g; rv_pct = v; rdy_pct = r;
  endtask

  task automatic drive_idle();
    bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = 32'h0;
    bus.id_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b1;
    drive_idle();
    mem_q.delete(); fifo_q.delete(); gnt_q.delete(); del_q.delete();
    exp_fetch = RST_PC; trap_m = 1'b0; trap_addr = 32'h0; redir = 1'b0; redir_pc = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive memory/decode/redirect, sample outputs, advance the reference model.
  task automatic step();
    req_t r;
    bit fire, pop;
    logic [31:0] tgt;
    @(negedge clk);
    obs_rv = 1'b0;
    if (mem_q.size() > 0) obs_rv = (mem_q[0].cyc < cyc) && ($urandom_range(99) < rv_pct);
    bus.imem_rvalid_i = obs_rv;
    bus.imem_rdata_i  = obs_rv ? instr_of(mem_q[0].addr) : $urandom();
    obs_gnt = ($urandom_range(99) < gnt_pct);
    obs_rdy = ($urandom_range(99) < rdy_pct);
    bus.imem_gnt_i = obs_gnt;
    bus.id_ready_i = obs_rdy;
    redirect_i = redir; redirect_pc_i = redir_pc;
    #1;
    obs_req = bus.imem_req_o; obs_addr = bus.imem_addr_o; obs_valid = bus.id_valid_o;
    obs_pc = bus.id_pc_o; obs_plus4 = bus.id_pc_plus4_o; obs_instr = bus.id_instr_o;
    obs_mis = misalign_o; obs_mis_addr = misalign_addr_o;

    exp_req = !trap_m && (mem_q.size() + fifo_q.size() < DEPTH);
    foreach (mem_q[i]) if (mem_q[i].wrong) exp_req = 1'b0;
    exp_addr     = exp_fetch;
    exp_valid    = (fifo_q.size() > 0) && !redir;
    exp_pc       = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
    exp_mis      = trap_m;
    exp_mis_addr = trap_m ? trap_addr : 32'h0;

    if (obs_req && obs_gnt) gnt_q.push_back('{obs_addr, cyc});
    if (obs_valid && obs_rdy) del_q.push_back('{obs_pc, obs_plus4, obs_instr, cyc});

    fire = exp_req && obs_gnt;
    pop  = exp_valid && obs_rdy;
    if (obs_rv) r = mem_q.pop_front();
    if (redir) begin
      foreach (mem_q[i]) mem_q[i].wrong = 1'b1;
      if (fire) mem_q.push_back('{exp_fetch, cyc, 1'b1});
      fifo_q.delete();
      tgt = align_tgt(redir_pc);
      exp_fetch = tgt;
      trap_m = (tgt[1:0] != 2'b00);
      trap_addr = tgt;
    end else begin
      if (obs_rv && !r.wrong) fifo_q.push_back(r.addr);
      if (pop) fifo_q.delete(0);
      if (fire) begin
        mem_q.push_back('{exp_fetch, cyc, 1'b0});
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic test_reset();
    do_reset();
    set_knobs(100, 100, 100);
    repeat (5) step();
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    n_vec++; if (bus.imem_req_o !== 1'b0) begin n_err++; $display("FAIL reset_req got=%0b exp=0", bus.imem_req_o); end
    n_vec++; if (bus.imem_addr_o !== RST_PC) begin n_err++; $display("FAIL reset_addr got=%h exp=%h", bus.imem_addr_o, RST_PC); end
    n_vec++; if (bus.id_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b exp=0", bus.id_valid_o); end
    n_vec++; if ({bus.id_instr_o, bus.id_pc_o, bus.id_pc_plus4_o} !== 96'h0) begin n_err++; $display("FAIL reset_id got=%h/%h/%h exp=0", bus.id_instr_o, bus.id_pc_o, bus.id_pc_plus4_o); end
    n_vec++; if ({misalign_o, misalign_addr_o} !== 33'h0) begin n_err++; $display("FAIL reset_mis got=%0b/%h exp=0", misalign_o, misalign_addr_o); end
    do_reset();
    step();
    n_vec++; if (obs_req !== 1'b1 || obs_addr !== RST_PC) begin n_err++; $display("FAIL reset_first_req got=%0b@%h exp=1@%h", obs_req, obs_addr, RST_PC); end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    do_reset();
    set_knobs(100, 100, 100);
    repeat (12) step();
    n_vec++;
    if (gnt_q.size() < 4 || del_q.size() < 3) begin
      n_err++; $display("FAIL stream_count got=%0d/%0d exp>=4/3", gnt_q.size(), del_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++; if (gnt_q[i].addr !== 32'(4 * i)) begin n_err++; $display("FAIL stream_addr%0d got=%h exp=%h", i, gnt_q[i].addr, 32'(4 * i)); end
      end
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (del_q[i].pc !== 32'(4 * i) || del_q[i].plus4 !== 32'(4 * i + 4) || del_q[i].instr !== instr_of(32'(4 * i))) begin
          n_err++; $display("FAIL stream_id%0d got=%h/%h/%h exp=%h/%h/%h", i, del_q[i].pc, del_q[i].plus4, del_q[i].instr, 32'(4 * i), 32'(4 * i + 4), instr_of(32'(4 * i)));
        end
      end
      n_vec++; if (del_q[0].cyc !== gnt_q[0].cyc + 2) begin n_err++; $display("FAIL stream_latency got=%0d exp=%0d", del_q[0].cyc - gnt_q[0].cyc, 2); end
    end
    $display("test_stream done: %0d grants, %0d delivered", gnt_q.size(), del_q.size());
  endtask

  task automatic test_backpressure();
    do_reset();
    set_knobs(100, 100, 0);
    repeat (8) step();
    n_vec++; if (gnt_q.size() !== 2) begin n_err++; $display("FAIL bp_grants got=%0d exp=2", gnt_q.size()); end
    n_vec++; if (obs_req !== 1'b0) begin n_err++; $display("FAIL bp_req got=%0b exp=0", obs_req); end
    n_vec++; if (obs_valid !== 1'b1 || obs_pc !== 32'h0) begin n_err++; $display("FAIL bp_head got=%0b@%h exp=1@0", obs_valid, obs_pc); end
    set_knobs(100, 100, 100);
    repeat (8) step();
    n_vec++;
    if (del_q.size() < 3 || del_q[0].pc !== 32'h0 || del_q[1].pc !== 32'h4 || del_q[2].pc !== 32'h8) begin
      n_err++; $display("FAIL bp_order got_n=%0d first=%h exp=0,4,8", del_q.size(), (del_q.size() > 0) ? del_q[0].pc : 32'hx);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_redirect_drain();
    int rc, gi, di;
    do_reset();
    set_knobs(100, 0, 0);
    repeat (4) step();
    n_vec++; if (gnt_q.size() !== 2) begin n_err++; $display("FAIL drain_outstanding got=%0d exp=2", gnt_q.size()); end
    redir = 1'b1; redir_pc = 32'h100;
    step();
    rc = cyc - 1;
    redir = 1'b0;
    set_knobs(100, 100, 100);
    step();
    n_vec++; if (obs_req !== 1'b0) begin n_err++; $display("FAIL drain_req got=%0b exp=0", obs_req); end
    repeat (10) step();
    gi = first_gnt(rc); di = first_del(rc);
    n_vec++; if (gi < 0 || gnt_q[gi].addr !== 32'h100) begin n_err++; $display("FAIL drain_addr got=%h exp=100", (gi < 0) ? 32'hx : gnt_q[gi].addr); end
    n_vec++; if (del_q.size() < 1 || del_q[0].pc !== 32'h100 || di != 0) begin n_err++; $display("FAIL drain_first_id got=%h exp=100", (del_q.size() > 0) ? del_q[0].pc : 32'hx); end
    $display("test_redirect_drain done");
  endtask

  task automatic test_redirect_collide();
    int rc, gi, di;
    do_reset();
    set_knobs(100, 100, 100);
    repeat (4) step();
    redir = 1'b1; redir_pc = 32'h200;
    step();
    rc = cyc - 1;
    redir = 1'b0;
    n_vec++; if (obs_req !== 1'b1 || obs_valid !== 1'b0) begin n_err++; $display("FAIL collide_redirect_cycle got req=%0b valid=%0b exp req=1 valid=0", obs_req, obs_valid); end
    step();
    n_vec++; if (obs_req !== 1'b0) begin n_err++; $display("FAIL collide_drain_req got=%0b exp=0", obs_req); end
    repeat (8) step();
    gi = first_gnt(rc); di = first_del(rc);
    n_vec++; if (gi < 0 || gnt_q[gi].addr !== 32'h200) begin n_err++; $display("FAIL collide_addr got=%h exp=200", (gi < 0) ? 32'hx : gnt_q[gi].addr); end
    n_vec++; if (di < 0 || del_q[di].pc !== 32'h200) begin n_err++; $display("FAIL collide_first_id got=%h exp=200", (di < 0) ? 32'hx : del_q[di].pc); end
    $display("test_redirect_collide done");
  endtask

  task automatic test_wrap();
    int rc, gi, di;
    do_reset();
    set_knobs(100, 100, 100);
    redir = 1'b1; redir_pc = 32'hFFFF_FFF8;
    step();
    rc = cyc - 1;
    redir = 1'b0;
    repeat (10) step();
    gi = first_gnt(rc); di = first_del(rc);
    n_vec++;
    if (gi < 0 || gi + 2 >= gnt_q.size()) begin
      n_err++; $display("FAIL wrap_grants got_n=%0d exp>=3", gnt_q.size());
    end else if (gnt_q[gi].addr !== 32'hFFFF_FFF8 || gnt_q[gi+1].addr !== 32'hFFFF_FFFC || gnt_q[gi+2].addr !== 32'h0) begin
      n_err++; $display("FAIL wrap_addr got=%h,%h,%h exp=fffffff8,fffffffc,00000000", gnt_q[gi].addr, gnt_q[gi+1].addr, gnt_q[gi+2].addr);
    end
    n_vec++;
    if (di < 0 || di + 1 >= del_q.size() || del_q[di+1].pc !== 32'hFFFF_FFFC || del_q[di+1].plus4 !== 32'h0) begin
      n_err++; $display("FAIL wrap_plus4 got=%h exp=00000000", (di < 0 || di + 1 >= del_q.size()) ? 32'hx : del_q[di+1].plus4);
    end
    $display("test_wrap done");
  endtask

  task automatic test_misalign();
    int rc, gi, di;
    do_reset();
    set_knobs(100, 100, 100);
    repeat (3) step();
    redir = 1'b1; redir_pc = 32'h102;
    step();
    rc = cyc - 1;
    redir = 1'b0;
    repeat (6) step();
    gi = first_gnt(rc); di = first_del(rc);
`ifdef MISALIGN_TRAP_EN
    n_vec++; if (obs_mis !== 1'b1 || obs_mis_addr !== 32'h102) begin n_err++; $display("FAIL mis_trap got=%0b/%h exp=1/102", obs_mis, obs_mis_addr); end
    n_vec++; if (gi >= 0 || obs_req !== 1'b0 || obs_valid !== 1'b0) begin n_err++; $display("FAIL mis_nofetch got grant_idx=%0d req=%0b valid=%0b exp none", gi, obs_req, obs_valid); end
    redir = 1'b1; redir_pc = 32'h200;
    step();
    rc = cyc - 1;
    redir = 1'b0;
    repeat (8) step();
    gi = first_gnt(rc);
    n_vec++; if (gi < 0 || gnt_q[gi].addr !== 32'h200) begin n_err++; $display("FAIL mis_resume got=%h exp=200", (gi < 0) ? 32'hx : gnt_q[gi].addr); end
    n_vec++; if (obs_mis !== 1'b0 || obs_mis_addr !== 32'h0) begin n_err++; $display("FAIL mis_clear got=%0b/%h exp=0/0", obs_mis, obs_mis_addr); end
`else
    n_vec++; if (gi < 0 || gnt_q[gi].addr !== 32'h100) begin n_err++; $display("FAIL mis_align_addr got=%h exp=100", (gi < 0) ? 32'hx : gnt_q[gi].addr); end
    n_vec++; if (di < 0 || del_q[di].pc !== 32'h100) begin n_err++; $display("FAIL mis_align_id got=%h exp=100", (di < 0) ? 32'hx : del_q[di].pc); end
    n_vec++; if (obs_mis !== 1'b0 || obs_mis_addr !== 32'h0) begin n_err++; $display("FAIL mis_tied got=%0b/%h exp=0/0", obs_mis, obs_mis_addr); end
`endif
    $display("test_misalign done");
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) set_knobs($urandom_range(20, 100), $urandom_range(20, 100), $urandom_range(10, 100));
      redir = ($urandom_range(99) < 4);
      case ($urandom_range(3))
        0:       redir_pc = $urandom() & 32'h0000_0FFC;
        1:       redir_pc = 32'hFFFF_FFF0 + 32'($urandom_range(3) * 4);
        2:       redir_pc = ($urandom() & 32'h0000_FFFC) | 32'($urandom_range(1, 3));
        default: redir_pc = $urandom() & 32'hFFFF_FFFC;
      endcase
      step();
      n_vec++; if (obs_req !== exp_req) begin n_err++; $display("FAIL rnd_req cyc=%0d got=%0b exp=%0b", cyc - 1, obs_req, exp_req); end
      if (exp_req) begin
        n_vec++; if (obs_addr !== exp_addr) begin n_err++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc - 1, obs_addr, exp_addr); end
      end
      n_vec++; if (obs_valid !== exp_valid) begin n_err++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", cyc - 1, obs_valid, exp_valid); end
      if (exp_valid) begin
        n_vec++;
        if (obs_pc !== exp_pc || obs_plus4 !== exp_pc + 32'd4 || obs_instr !== instr_of(exp_pc)) begin
          n_err++; $display("FAIL rnd_id cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc - 1, obs_pc, obs_plus4, obs_instr, exp_pc, exp_pc + 32'd4, instr_of(exp_pc));
        end
      end
      n_vec++; if (obs_mis !== exp_mis || obs_mis_addr !== exp_mis_addr) begin n_err++; $display("FAIL rnd_mis cyc=%0d got=%0b/%h exp=%0b/%h", cyc - 1, obs_mis, obs_mis_addr, exp_mis, exp_mis_addr); end
    end
    redir = 1'b0;
    $display("test_random done: %0d grants, %0d delivered", gnt_q.size(), del_q.size());
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    set_knobs(0, 0, 0);
    redir = 1'b0; redir_pc = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drain();
    test_redirect_collide();
    test_wrap();
    test_misalign();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
